issue_queue: RTL and testbench

//  Parametrised multi-lane in-order instruction queue between frontend and dispatch.

---
 rtl/issue_queue_if.sv | 28 ++
 rtl/issue_queue.sv | 141 ++++++++++++++
 tb/tb_issue_queue.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/issue_queue_if.sv
// Frontend/dispatch bundle for issue_queue.
// master: frontend + dispatch side (drives enq lanes, flush, pop count).
// slave : the queue itself.
interface issue_queue_if #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 8,
    parameter int ENQ_W  = 2,
    parameter int DEQ_W  = 2
);
    logic                         flush;
    logic [ENQ_W-1:0]             enq_valid;
    logic [ENQ_W*DATA_W-1:0]      enq_data;
    logic                         enq_ready;
    logic [DEQ_W-1:0]             deq_valid;
    logic [DEQ_W*DATA_W-1:0]      deq_data;
    logic [$clog2(DEQ_W+1)-1:0]   deq_pop_cnt;
    logic [$clog2(DEPTH+1)-1:0]   occupancy;

    modport master (
        output flush, enq_valid, enq_data, deq_pop_cnt,
        input  enq_ready, deq_valid, deq_data, occupancy
    );

    modport slave (
        input  flush, enq_valid, enq_data, deq_pop_cnt,
        output enq_ready, deq_valid, deq_data, occupancy
    );
endinterface

// File: rtl/issue_queue.sv
// issue_queue: multi-lane in-order instruction queue between decode and dispatch.
// Accepts up to ENQ_W entries per cycle (all-or-nothing), presents the oldest
// DEQ_W entries combinationally, and retires 0..DEQ_W of them per cycle.
// Optional macro ISSUE_QUEUE_BYPASS_EN: while the queue is empty, enqueue lanes
// are shown directly on the dequeue lanes in the same cycle; lanes popped that
// cycle are never written to storage.

// One dequeue lane: picks between the stored entry and the bypassed enq lane.
module issue_queue_lane #(
    parameter int DATA_W = 64
) (
    input  logic              stored_valid,
    input  logic [DATA_W-1:0] stored_data,
    input  logic              byp_sel,
    input  logic              byp_valid,
    input  logic [DATA_W-1:0] byp_data,
    output logic              valid,
    output logic [DATA_W-1:0] data
);
    // bypass view wins only while the queue holds nothing
    always_comb begin
        valid = byp_sel ? byp_valid : stored_valid;
        data  = byp_sel ? byp_data  : stored_data;
    end
endmodule

module issue_queue #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 8,
    parameter int ENQ_W  = 2,
    parameter int DEQ_W  = 2
) (
    input logic          clk,
    input logic          rst,
    issue_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [OCC_W-1:0]  occupancy;

    logic [ENQ_W-1:0][DATA_W-1:0] enq_lane;
    logic [DEQ_W-1:0][DATA_W-1:0] stored_data;
    logic [DEQ_W-1:0][DATA_W-1:0] byp_data;
    logic [DEQ_W-1:0][DATA_W-1:0] lane_data;
    logic [DEQ_W-1:0]             stored_valid;
    logic [DEQ_W-1:0]             byp_valid;
    logic [DEQ_W-1:0]             lane_valid;

    logic enq_ready;
    logic byp;
    logic accepted;
    int   occ;
    int   enq_n;
    int   visible;
    int   pop_n;
    int   skip;

    assign enq_lane = bus.enq_data;

`ifdef ISSUE_QUEUE_BYPASS_EN
    assign byp = (occupancy == '0) && !bus.flush;
`else
    assign byp = 1'b0;
`endif

    // count leading valid lanes, derive acceptance and the number retired this cycle
    always_comb begin
        logic run;
        run     = 1'b1;
        enq_n   = 0;
        occ     = int'(occupancy);
        for (int i = 0; i < ENQ_W; i++) begin
            if (run && bus.enq_valid[i]) enq_n = enq_n + 1;
            else                         run   = 1'b0;
        end
        // ready looks only at registered occupancy so pops never reach enq_ready
        enq_ready = (DEPTH - occ) >= ENQ_W;
        accepted  = enq_ready && (enq_n > 0) && !bus.flush;
        if (byp) visible = enq_ready ? ((enq_n < DEQ_W) ? enq_n : DEQ_W) : 0;
        else     visible = (occ < DEQ_W) ? occ : DEQ_W;
        pop_n = int'(bus.deq_pop_cnt);
        if (pop_n > visible) pop_n = visible;
        if (bus.flush)       pop_n = 0;
        // bypassed lanes that are consumed at once never occupy a slot
        skip = byp ? pop_n : 0;
    end

    // per-lane read view
    for (genvar i = 0; i < DEQ_W; i++) begin : g_lane
        assign stored_valid[i] = int'(occupancy) > i;
        assign stored_data[i]  = mem[head + PTR_W'(i)];
        if (i < ENQ_W) begin : g_byp
            assign byp_valid[i] = (i < enq_n) && enq_ready;
            assign byp_data[i]  = enq_lane[i];
        end else begin : g_nobyp
            assign byp_valid[i] = 1'b0;
            assign byp_data[i]  = '0;
        end
        issue_queue_lane #(.DATA_W(DATA_W)) u_lane (
            .stored_valid (stored_valid[i]),
            .stored_data  (stored_data[i]),
            .byp_sel      (byp),
            .byp_valid    (byp_valid[i]),
            .byp_data     (byp_data[i]),
            .valid        (lane_valid[i]),
            .data         (lane_data[i])
        );
    end

    assign bus.deq_valid = lane_valid;
    assign bus.deq_data  = lane_data;
    assign bus.enq_ready = enq_ready;
    assign bus.occupancy = occupancy;

    // pointer and occupancy update; rst beats flush, flush beats enq/pop
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
        end else begin
            head      <= head + PTR_W'(pop_n - skip);
            tail      <= tail + PTR_W'(accepted ? (enq_n - skip) : 0);
            occupancy <= OCC_W'(occ + (accepted ? enq_n : 0) - pop_n);
        end
    end

    // entry storage; not cleared by reset, writes only accepted, non-bypassed lanes
    always_ff @(posedge clk) begin
        if (!rst && accepted) begin
            for (int j = 0; j < ENQ_W; j++) begin
                if (j < enq_n && j >= skip)
                    mem[tail + PTR_W'(j - skip)] <= enq_lane[j];
            end
        end
    end
endmodule

// File: tb/tb_issue_queue.sv
// Scoreboard bench for issue_queue (DEPTH=8, ENQ_W=DEQ_W=2, DATA_W=64).
// Driver updates a queue model and pushes the expected per-cycle view; a monitor
// pops and compares at each negedge. Directed spot checks use hand values.
module tb_issue_queue;
    localparam int DW    = 64;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    issue_queue_if #(.DATA_W(DW), .DEPTH(DEPTH), .ENQ_W(2), .DEQ_W(2)) bus ();

    issue_queue #(.DATA_W(DW), .DEPTH(DEPTH), .ENQ_W(2), .DEQ_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit          chk;
        int          occ;
        bit          rdy;
        bit [1:0]    vld;
        logic [63:0] d0;
        logic [63:0] d1;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] mq[$];
    int          nvec = 0;
    int          nerr = 0;
    bit          init = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // one clock of stimulus plus model update
    task automatic cyc(input bit r, input bit f, input bit [1:0] ev,
                       input logic [63:0] a, input logic [63:0] b, input int pop);
        exp_t        e;
        logic [63:0] view[$];
        int          occ, n, pn, vis;
        bit          rdy, byp;
        @(posedge clk); #1;
        rst = r; bus.flush = f; bus.enq_valid = ev;
        bus.enq_data = {b, a}; bus.deq_pop_cnt = 2'(pop);
        occ  = mq.size();
        n    = ev[0] ? (ev[1] ? 2 : 1) : 0;
        rdy  = (DEPTH - occ) >= 2;
        view = mq;
        byp  = 1'b0;
`ifdef ISSUE_QUEUE_BYPASS_EN
        byp = (occ == 0) && !f;
        if (byp) begin
            view.delete();
            if (rdy && n > 0) view.push_back(a);
            if (rdy && n > 1) view.push_back(b);
        end
`endif
        e.chk = init; e.occ = occ; e.rdy = rdy;
        e.vld = {view.size() > 1, view.size() > 0};
        e.d0  = (view.size() > 0) ? view[0] : 64'h0;
        e.d1  = (view.size() > 1) ? view[1] : 64'h0;
        sb.push_back(e);
        if (r) begin
            mq.delete(); init = 1;
        end else if (f) begin
            mq.delete();
        end else begin
            vis = (view.size() > 2) ? 2 : view.size();
            pn  = (pop < vis) ? pop : vis;
            if (byp) begin
                for (int k = pn; k < view.size(); k++) mq.push_back(view[k]);
            end else begin
                repeat (pn) void'(mq.pop_front());
                if (rdy && n > 0) mq.push_back(a);
                if (rdy && n > 1) mq.push_back(b);
            end
        end
    endtask

    task automatic idle();
        cyc(0, 0, 2'b00, 64'h0, 64'h0, 0);
    endtask

    // monitor: compare DUT view against the expected view for this cycle
    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.chk) begin
                    check("sb_occupancy", 64'(bus.occupancy), 64'(e.occ));
                    check("sb_enq_ready", 64'(bus.enq_ready), 64'(e.rdy));
                    check("sb_deq_valid", 64'(bus.deq_valid), 64'(e.vld));
                    if (e.vld[0]) check("sb_deq_data0", bus.deq_data[63:0],   e.d0);
                    if (e.vld[1]) check("sb_deq_data1", bus.deq_data[127:64], e.d1);
                end
            end
        end
    end

    initial begin
        int cnt, sel, n;
        logic [63:0] a, b;
        rst = 1'b1; bus.flush = 1'b0; bus.enq_valid = '0; bus.enq_data = '0; bus.deq_pop_cnt = '0;

        // reset, with flush/enq during the second reset cycle
        cyc(1, 0, 2'b00, 64'h0, 64'h0, 0);
        cyc(1, 1, 2'b11, 64'h99, 64'h98, 2);
        idle(); @(negedge clk);
        check("rst_occ", 64'(bus.occupancy), 64'd0);
        check("rst_rdy", 64'(bus.enq_ready), 64'd1);
        check("rst_vld", 64'(bus.deq_valid), 64'd0);

        // fill to full
        for (int c = 0; c < 4; c++) cyc(0, 0, 2'b11, 64'(16 + 2*c), 64'(17 + 2*c), 0);
        idle(); @(negedge clk);
        check("full_occ", 64'(bus.occupancy), 64'd8);
        check("full_rdy", 64'(bus.enq_ready), 64'd0);
        check("full_d0",  bus.deq_data[63:0],   64'h10);
        check("full_d1",  bus.deq_data[127:64], 64'h11);

        // simultaneous enq+pop at 6; blocked enq at 7
        cyc(0, 0, 2'b00, 64'h0, 64'h0, 2);
        cyc(0, 0, 2'b11, 64'h18, 64'h19, 2);
        idle(); @(negedge clk);
        check("mix_occ", 64'(bus.occupancy), 64'd6);
        check("mix_d0",  bus.deq_data[63:0], 64'h14);
        cyc(0, 0, 2'b00, 64'h0, 64'h0, 1);
        cyc(0, 0, 2'b11, 64'h1a, 64'h1b, 0);
        cyc(0, 0, 2'b11, 64'h1c, 64'h1d, 2); @(negedge clk);
        check("occ7_rdy", 64'(bus.enq_ready), 64'd0);
        idle(); @(negedge clk);
        check("occ7_occ", 64'(bus.occupancy), 64'd5);
        check("occ7_d0",  bus.deq_data[63:0], 64'h17);

        // flush overrides enq and pop
        cyc(0, 1, 2'b11, 64'h20, 64'h21, 1);
        idle(); @(negedge clk);
        check("flush_occ", 64'(bus.occupancy), 64'd0);
        check("flush_vld", 64'(bus.deq_valid), 64'd0);
        check("flush_rdy", 64'(bus.enq_ready), 64'd1);

        // random enq/pop with increasing values across pointer wrap
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       begin n = 0; cyc(0, 0, 2'b00, 64'h0, 64'h0, $urandom_range(0, 2)); end
                1:       begin n = 1; a = 64'(cnt); cyc(0, 0, 2'b01, a, 64'hdead, $urandom_range(0, 2)); end
                2:       begin n = 2; a = 64'(cnt); b = 64'(cnt + 1); cyc(0, 0, 2'b11, a, b, $urandom_range(0, 2)); end
                default: begin n = 0; cyc(0, 0, 2'b10, 64'hbeef, 64'hbeef, $urandom_range(0, 2)); end
            endcase
            // model already updated; advance values only if those lanes were taken
            if (n > 0 && mq.size() > 0 && mq[mq.size()-1] == 64'(cnt + n - 1)) cnt = cnt + n;
        end

        // over-pop clipped at occupancy 1
        cyc(0, 1, 2'b00, 64'h0, 64'h0, 0);
        cyc(0, 0, 2'b01, 64'h55, 64'h0, 0);
        cyc(0, 0, 2'b00, 64'h0, 64'h0, 2);
        idle(); @(negedge clk);
        check("overpop_occ", 64'(bus.occupancy), 64'd0);
        check("overpop_vld", 64'(bus.deq_valid), 64'd0);

        // reset mid-stream discards entries
        cyc(0, 0, 2'b11, 64'h61, 64'h62, 0);
        cyc(0, 0, 2'b11, 64'h63, 64'h64, 0);
        cyc(1, 0, 2'b11, 64'h65, 64'h66, 1);
        idle(); @(negedge clk);
        check("midrst_occ", 64'(bus.occupancy), 64'd0);
        check("midrst_vld", 64'(bus.deq_valid), 64'd0);

        // empty queue: enq 0x11/0x22 with pop 1
        cyc(0, 0, 2'b11, 64'h11, 64'h22, 1); @(negedge clk);
`ifdef ISSUE_QUEUE_BYPASS_EN
        check("empty_vld0", 64'(bus.deq_valid[0]), 64'd1);
        check("empty_d0",   bus.deq_data[63:0], 64'h11);
        idle(); @(negedge clk);
        check("empty_occ_next", 64'(bus.occupancy), 64'd1);
        check("empty_d0_next",  bus.deq_data[63:0], 64'h22);
`else
        check("empty_vld", 64'(bus.deq_valid), 64'd0);
        idle(); @(negedge clk);
        check("empty_occ_next", 64'(bus.occupancy), 64'd2);
        check("empty_d0_next",  bus.deq_data[63:0], 64'h11);
`endif

        repeat (2) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
